// File: rtl/prog_moore_fsm.sv
// Table-programmable Moore machine: next-state and output tables held in
// registers, loaded through a one-entry-per-edge config write port.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   en, in_v   take one transition on in_v when en=1, else hold
//   cfg_*      table write: cfg_sel=0 -> NS[cfg_state][cfg_in],
//              cfg_sel=1 -> OUT[cfg_state]; data in low bits of cfg_data
//   st         current state register
//   out_v      OUT[st], combinational
//   chg, err   one-cycle flags: state changed / illegal target taken
module prog_moore_fsm #(
    parameter  int NUM_STATES  = 8,
    parameter  int IN_W        = 2,
    parameter  int OUT_W       = 2,
    parameter  int RESET_STATE = 0,
    localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
    localparam int DW = (SW > OUT_W) ? SW : OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in_v,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [SW-1:0]    cfg_state,
    input  logic [IN_W-1:0]  cfg_in,
    input  logic [DW-1:0]    cfg_data,
    output logic [SW-1:0]    st,
    output logic [OUT_W-1:0] out_v,
    output logic             chg,
    output logic             err
);

    localparam int NIN = 2 ** IN_W;
    localparam logic [SW-1:0] RST_ST = SW'(RESET_STATE);

    logic [SW-1:0]    ns_tab  [NUM_STATES][NIN];
    logic [OUT_W-1:0] out_tab [NUM_STATES];

    logic [SW-1:0] tgt;
    logic          legal;
    logic [SW-1:0] st_nx;
    logic          chg_nx;
    logic          err_nx;

    // Table reads decoded by comparison so unused state codes
    // never index past the end of the tables.
    always_comb begin
        tgt   = RST_ST;
        out_v = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (st == SW'(i)) begin
                tgt   = ns_tab[i][in_v];
                out_v = out_tab[i];
            end
        end
    end

    // With a power-of-two state count every code is legal.
    if (NUM_STATES == (1 << SW)) begin : g_full
        assign legal = 1'b1;
    end else begin : g_part
        assign legal = (tgt < SW'(NUM_STATES));
    end

    always_comb begin
        st_nx  = st;
        chg_nx = 1'b0;
        err_nx = 1'b0;
        if (en) begin
            if (legal) begin
                st_nx = tgt;
            end else begin
                st_nx  = RST_ST;
                err_nx = 1'b1;
            end
            chg_nx = (st_nx != st);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= RST_ST;
            chg <= 1'b0;
            err <= 1'b0;
        end else begin
            st  <= st_nx;
            chg <= chg_nx;
            err <= err_nx;
        end
    end

    // Writes land after the transition has read the old entry,
    // so a same-edge write only affects later edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                out_tab[i] <= '0;
                for (int j = 0; j < NIN; j++) begin
                    ns_tab[i][j] <= RST_ST;
                end
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                if (cfg_state == SW'(i)) begin
                    if (cfg_sel) begin
                        out_tab[i] <= cfg_data[OUT_W-1:0];
                    end else begin
                        ns_tab[i][cfg_in] <= cfg_data[SW-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Bench for prog_moore_fsm with 6 states: directed scenarios plus
// randomized traffic checked against a table-level reference model.
module tb_prog_moore_fsm;

    localparam int NS = 6;
    localparam int RS = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] in_v;
    logic       cfg_we;
    logic       cfg_sel;
    logic [2:0] cfg_state;
    logic [1:0] cfg_in;
    logic [2:0] cfg_data;
    logic [2:0] st;
    logic [1:0] out_v;
    logic       chg;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    int ns_m [NS][4];
    int out_m [NS];
    int st_m, chg_m, err_m;

    prog_moore_fsm #(
        .NUM_STATES (NS),
        .IN_W       (2),
        .OUT_W      (2),
        .RESET_STATE(RS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_v     (in_v),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_state(cfg_state),
        .cfg_in   (cfg_in),
        .cfg_data (cfg_data),
        .st       (st),
        .out_v    (out_v),
        .chg      (chg),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference: apply one edge using the currently driven inputs.
    task automatic model_edge();
        int t, nst;
        if (rst) begin
            st_m = RS; chg_m = 0; err_m = 0;
            for (int s = 0; s < NS; s++) begin
                out_m[s] = 0;
                for (int i = 0; i < 4; i++) ns_m[s][i] = RS;
            end
        end else begin
            if (en) begin
                t = ns_m[st_m][int'(in_v)];
                if (t < NS) begin
                    nst = t; err_m = 0;
                end else begin
                    nst = RS; err_m = 1;
                end
                chg_m = (nst != st_m) ? 1 : 0;
                st_m  = nst;
            end else begin
                chg_m = 0; err_m = 0;
            end
            if (cfg_we && int'(cfg_state) < NS) begin
                if (cfg_sel) out_m[cfg_state] = int'(cfg_data[1:0]);
                else ns_m[cfg_state][cfg_in] = int'(cfg_data);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input int s,
                             input int i, input int d);
        en        = 1'b0;
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_state = 3'(s);
        cfg_in    = 2'(i);
        cfg_data  = 3'(d);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic step(input int iv);
        en   = 1'b1;
        in_v = 2'(iv);
        tick();
        en   = 1'b0;
    endtask

    task automatic rand_drive();
        rst       = 1'b0;
        en        = ($urandom_range(0, 9) < 7);
        in_v      = 2'($urandom_range(0, 3));
        cfg_we    = ($urandom_range(0, 9) < 4);
        cfg_sel   = 1'($urandom_range(0, 1));
        cfg_state = 3'($urandom_range(0, 7));
        cfg_in    = 2'($urandom_range(0, 3));
        cfg_data  = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        for (int c = 0; c < 30; c++) begin
            rand_drive();
            tick();
        end
        rand_drive();
        en  = 1'b1;
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        cfg_we = 1'b0;
        n_tests++;
        if (st !== 3'd0 || out_v !== 2'd0 || chg !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: st=%0d out=%0d chg=%0d err=%0d want 0 0 0 0",
                     st, out_v, chg, err);
        end
        for (int i = 0; i < 4; i++) begin
            step(i);
            n_tests++;
            if (st !== 3'd0 || chg !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ns in=%0d: st=%0d chg=%0d err=%0d want 0 0 0",
                         i, st, chg, err);
            end
        end
    endtask

    task automatic test_walk();
        cfg_write(1'b0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cfg_write(1'b0, 1, i, 2);
        cfg_write(1'b1, 1, 0, 1);
        cfg_write(1'b1, 2, 0, 3);
        n_tests++;
        if (st !== 3'd0 || out_v !== 2'b00) begin
            n_fail++;
            $display("FAIL walk0: st=%0d out=%0d want 0 0", st, out_v);
        end
        step(1);
        n_tests++;
        if (st !== 3'd1 || out_v !== 2'b01 || chg !== 1'b1) begin
            n_fail++;
            $display("FAIL walk1: st=%0d out=%0d chg=%0d want 1 1 1", st, out_v, chg);
        end
        step(0);
        n_tests++;
        if (st !== 3'd2 || out_v !== 2'b11 || chg !== 1'b1) begin
            n_fail++;
            $display("FAIL walk2: st=%0d out=%0d chg=%0d want 2 3 1", st, out_v, chg);
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 3; c++) begin
            en   = 1'b0;
            in_v = 2'(c);
            tick();
            n_tests++;
            if (st !== 3'd2 || out_v !== 2'b11 || chg !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d: st=%0d out=%0d chg=%0d err=%0d want 2 3 0 0",
                         c, st, out_v, chg, err);
            end
        end
        cfg_write(1'b1, 2, 0, 2);
        n_tests++;
        if (st !== 3'd2 || out_v !== 2'b10) begin
            n_fail++;
            $display("FAIL out_wr_cur: st=%0d out=%0d want 2 2", st, out_v);
        end
        cfg_write(1'b1, 2, 0, 3);
    endtask

    task automatic test_illegal();
        cfg_write(1'b0, 2, 0, 7);
        step(0);
        n_tests++;
        if (st !== 3'd0 || err !== 1'b1 || chg !== 1'b1 || out_v !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal: st=%0d err=%0d chg=%0d out=%0d want 0 1 1 0",
                     st, err, chg, out_v);
        end
        tick();
        n_tests++;
        if (err !== 1'b0 || st !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_clr: err=%0d st=%0d want 0 0", err, st);
        end
    endtask

    task automatic test_same_edge();
        step(1);
        en        = 1'b1;
        in_v      = 2'd3;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_state = 3'd1;
        cfg_in    = 2'd3;
        cfg_data  = 3'd3;
        tick();
        cfg_we = 1'b0;
        n_tests++;
        if (st !== 3'd2 || chg !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_old: st=%0d chg=%0d want 2 1", st, chg);
        end
        step(0);
        step(1);
        step(3);
        n_tests++;
        if (st !== 3'd3 || out_v !== 2'b00) begin
            n_fail++;
            $display("FAIL same_edge_new: st=%0d out=%0d want 3 0", st, out_v);
        end
    endtask

    task automatic test_reset_mid();
        en   = 1'b1;
        in_v = 2'd0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        n_tests++;
        if (st !== 3'd0 || out_v !== 2'b00 || chg !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: st=%0d out=%0d chg=%0d err=%0d want 0 0 0 0",
                     st, out_v, chg, err);
        end
        cfg_write(1'b1, 6, 0, 3);
        cfg_write(1'b0, 6, 1, 1);
        cfg_write(1'b1, 7, 0, 3);
        step(1);
        n_tests++;
        if (st !== 3'd0 || out_v !== 2'b00 || chg !== 1'b0) begin
            n_fail++;
            $display("FAIL tables_clr: st=%0d out=%0d chg=%0d want 0 0 0",
                     st, out_v, chg);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_drive();
            rst = ($urandom_range(0, 49) == 0);
            tick();
            n_tests++;
            if (int'(st) != st_m || int'(out_v) != out_m[st_m]
                || int'(chg) != chg_m || int'(err) != err_m) begin
                n_fail++;
                $display("FAIL rand c%0d: st=%0d out=%0d chg=%0d err=%0d want %0d %0d %0d %0d",
                         c, st, out_v, chg, err, st_m, out_m[st_m], chg_m, err_m);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        in_v      = '0;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_state = '0;
        cfg_in    = '0;
        cfg_data  = '0;
        st_m      = RS;
        chg_m     = 0;
        err_m     = 0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_walk();
        test_hold();
        test_illegal();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
